// File: rtl/sm_pkg.sv
// Shared definitions for the 4-phase sequencer and its monitor:
// phase encoding and the monitor's state encoding.
package sm_pkg;

    localparam logic [1:0] PH_A = 2'b00;
    localparam logic [1:0] PH_B = 2'b01;
    localparam logic [1:0] PH_C = 2'b10;
    localparam logic [1:0] PH_D = 2'b11;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10,
        ERROR  = 2'b11
    } mon_state_t;

endpackage

// File: rtl/sm_phase_model.sv
// Expected-phase register mirroring the sequencer: load, hold or step by one,
// flagging when the model sits in phase D (where the sequencer drives z=1).
module sm_phase_model
    import sm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] load_val,
    input  logic       inc,
    output logic [1:0] ph,
    output logic       exp_z,
    output logic       at_d
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ph <= PH_A;
        else if (load)
            ph <= load_val;
        else if (inc)
            ph <= ph + 2'd1;
    end

    assign at_d  = (ph == PH_D);
    assign exp_z = at_d;

endmodule

// File: rtl/sm_monitor.sv
// Observer for the enable-stepped 4-phase sequencer: finds phase D from the
// first z pulse, tracks the phase, locks after clean wraps and flags mismatches.
module sm_monitor
    import sm_pkg::*;
#(
    parameter int LOCK_WRAPS = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             z,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int                GOOD_W   = $clog2(LOCK_WRAPS + 1);
    localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_WRAPS);

    mon_state_t        state, state_nxt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;
    logic              ph_load;
    logic [1:0]        ph_load_val;
    logic              ph_inc;
    logic [1:0]        ph;
    logic              exp_z;
    logic              at_d;
    logic              mis;
    logic              wrap;

    sm_phase_model u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_load_val),
        .inc      (ph_inc),
        .ph       (ph),
        .exp_z    (exp_z),
        .at_d     (at_d)
    );

    assign mis      = (z != exp_z);
    assign wrap     = at_d && en && !mis;
    assign good_inc = good + GOOD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    // A z pulse seen in HUNT is phase D; if en was high the sequencer has
    // already stepped on to A, otherwise it is still sitting in D.
    always_comb begin
        state_nxt   = state;
        ph_load     = 1'b0;
        ph_load_val = PH_A;
        ph_inc      = 1'b0;
        if (clr) begin
            ph_load   = 1'b1;
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    ph_load = 1'b1;
                    if (z) begin
                        ph_load_val = en ? PH_A : PH_D;
                        state_nxt   = TRACK;
                    end
                end
                TRACK: begin
                    if (mis) begin
                        ph_load   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        ph_inc = en;
                        if (wrap && good_inc == LOCK_VAL)
                            state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (mis)
                        state_nxt = ERROR;
                    else
                        ph_inc = en;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
        err    = (state == ERROR);
        phase  = (state == HUNT) ? PH_A : ph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            good <= '0;
        else if (clr || state == HUNT || (state == TRACK && mis))
            good <= '0;
        else if (state == TRACK && wrap && good != LOCK_VAL)
            good <= good_inc;
    end

    // Both counters saturate at all-ones rather than rolling over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr) begin
            wrap_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if ((state == TRACK || state == LOCKED) && wrap && wrap_cnt != '1)
                wrap_cnt <= wrap_cnt + CNT_W'(1);
            if (state == LOCKED && mis && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
